// File: rtl/nibble_add_seq_if.sv
// Operand/result handshake bundle for nibble_add_seq.
// The sub select exists only when NIBBLE_ADD_SEQ_SUB_EN is defined.
interface nibble_add_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, sub,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin,
    output out_ready,
    input  in_ready, out_valid,
    input  sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin,
    input  out_ready,
    output in_ready, out_valid,
    output sum, cout, busy
  );
`endif

endinterface

// File: rtl/nibble_add_seq.sv
// Nibble-serial adder: one shared 4-bit ripple slice, LSB nibble first.
// Define NIBBLE_ADD_SEQ_SUB_EN to add the sub (a - b) select.
module nibble_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  nibble_add_seq_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cy;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             valid_r;
  logic             busy_r;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  logic             sub_r;
`endif

  logic [3:0] na;
  logic [3:0] nb;
  logic [3:0] ns;
  logic [4:0] rc;

  // Shared 4-bit ripple slice fed by the current nibble.
  always_comb begin
    na = a_r[4*idx +: 4];
    nb = b_r[4*idx +: 4];
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    if (sub_r) nb = ~b_r[4*idx +: 4];
`endif
    ns    = '0;
    rc    = '0;
    rc[0] = cy;
    for (int i = 0; i < 4; i++) begin
      ns[i]   = na[i] ^ nb[i] ^ rc[i];
      rc[i+1] = (na[i] & nb[i])
              | (rc[i] & (na[i] ^ nb[i]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      cy      <= 1'b0;
      idx     <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r    <= bus.a;
            b_r    <= bus.b;
            idx    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
            sub_r  <= bus.sub;
            cy     <= bus.sub | bus.cin;
`else
            cy     <= bus.cin;
`endif
          end
        end
        RUN: begin
          sum_r[4*idx +: 4] <= ns;
          cy <= rc[4];
          if (idx == LAST) begin
            idx     <= '0;
            cout_r  <= rc[4];
            valid_r <= 1'b1;
            state   <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) & ~rst;
  assign bus.out_valid = valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq at WIDTH=16.
// Sub vectors run only when NIBBLE_ADD_SEQ_SUB_EN is defined.
module tb_nibble_add_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  nibble_add_seq_if #(.WIDTH(16)) bus ();

  nibble_add_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_op(input logic [15:0] ta,
                         input logic [15:0] tb_,
                         input logic tc);
    @(negedge clk);
    bus.a        = ta;
    bus.b        = tb_;
    bus.cin      = tc;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    bus.sub      = 1'b0;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
    bus.cin      = ~tc;
  endtask

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  task automatic send_sub(input logic [15:0] ta,
                          input logic [15:0] tb_,
                          input logic tc);
    @(negedge clk);
    bus.a        = ta;
    bus.b        = tb_;
    bus.cin      = tc;
    bus.sub      = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'hFFFF;
    bus.sub      = 1'b0;
  endtask
`endif

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 20 && bus.out_valid !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    bus.sub       = 1'b0;
`endif
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.sum !== 16'h0000 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL rst_sum: got %h/%b want 0000/0", bus.sum, bus.cout);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_ready: got %b/%b want 0/0",
               bus.busy, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    logic [15:0] va [6];
    logic [15:0] vb [6];
    logic        vc [6];
    logic [15:0] vs [6];
    logic        vo [6];
    int          n;
    va = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'hA5A5, 16'h0000, 16'h8000};
    vb = '{16'h4321, 16'h0001, 16'hFFFF, 16'h5A5A, 16'h0000, 16'h8000};
    vc = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    vs = '{16'h5555, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    vo = '{1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b1};
    for (int i = 0; i < 6; i++) begin
      send_op(va[i], vb[i], vc[i]);
      wait_valid(n);
      checks++;
      if (n !== 4) begin
        errors++;
        $display("FAIL add%0d_latency: got %0d want 4", i, n);
      end
      checks++;
      if (bus.sum !== vs[i] || bus.cout !== vo[i]) begin
        errors++;
        $display("FAIL add%0d_result: got %h/%b want %h/%b",
                 i, bus.sum, bus.cout, vs[i], vo[i]);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL add%0d_busy: got %b want 1", i, bus.busy);
      end
      consume();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL add%0d_release: got %b/%b want 0/1",
                 i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_hold();
    int n;
    send_op(16'h1111, 16'h2222, 1'b0);
    wait_valid(n);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d_flags: got %b/%b want 1/0",
                 k, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.sum !== 16'h3333 || bus.cout !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d_result: got %h/%b want 3333/0",
                 k, bus.sum, bus.cout);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: got %b/%b want 1/0",
               bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.out_ready = 1'b1;
    send_op(16'h0FFF, 16'h0001, 1'b0);
    wait_valid(n);
    checks++;
    if (bus.sum !== 16'h1000 || n !== 4) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d want 1000 lat 4",
               bus.sum, n);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_consumed: got %b/%b want 1/0",
               bus.in_ready, bus.out_valid);
    end
    send_op(16'h7FFF, 16'h7FFF, 1'b1);
    wait_valid(n);
    checks++;
    if (bus.sum !== 16'hFFFF || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got %h/%b want ffff/0",
               bus.sum, bus.cout);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    send_op(16'h1234, 16'h4321, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_flags: got %b/%b want 0/0",
               bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.sum !== 16'h0000 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_sum: got %h/%b want 0000/0",
               bus.sum, bus.in_ready);
    end
    #3;
    rst = 1'b0;
    send_op(16'h0F0F, 16'h00F1, 1'b0);
    wait_valid(n);
    checks++;
    if (bus.sum !== 16'h1000 || bus.cout !== 1'b0 || n !== 4) begin
      errors++;
      $display("FAIL midrst_next: got %h/%b lat %0d want 1000/0 lat 4",
               bus.sum, bus.cout, n);
    end
    consume();
  endtask

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  task automatic test_sub();
    int n;
    send_sub(16'h0005, 16'h0007, 1'b0);
    wait_valid(n);
    checks++;
    if (bus.sum !== 16'hFFFE || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_borrow: got %h/%b want fffe/0",
               bus.sum, bus.cout);
    end
    consume();
    send_sub(16'h0007, 16'h0005, 1'b1);
    wait_valid(n);
    checks++;
    if (bus.sum !== 16'h0002 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_noborrow: got %h/%b want 0002/1",
               bus.sum, bus.cout);
    end
    consume();
    send_op(16'h1234, 16'h4321, 1'b0);
    wait_valid(n);
    checks++;
    if (bus.sum !== 16'h5555 || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_off_add: got %h/%b want 5555/0",
               bus.sum, bus.cout);
    end
    consume();
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_hold();
    test_back_to_back();
    test_reset_mid();
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
